// File: rtl/tx_frame_scheduler.sv
`timescale 1ns/1ps
// Purpose: capture ALU/RegFile results, round-robin arbitrate, serialise to UART TX byte frames.
// Latency: 1 cycle from result capture to TX_D_VLD when idle and Busy low.
// Backpressure: one-deep slot per requester; a result arriving on a pending slot is dropped (Overrun_x).
// Ports: CLK/RST (async active-low); ALU_OUT/ALU_OUT_VLD and RdData/RdData_VLD results in;
//        Busy synchronised UART busy in; TX_P_Data/TX_D_VLD byte request out;
//        Overrun_ALU/Overrun_Rd/Tx_Timeout single-cycle pulses; Sched_Busy activity flag.
module tx_frame_scheduler #(
  parameter int ALU_WIDTH      = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ALU_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_VLD,
  input  logic                  Busy,
  output logic [DATA_WIDTH-1:0] TX_P_Data,
  output logic                  TX_D_VLD,
  output logic                  Overrun_ALU,
  output logic                  Overrun_Rd,
  output logic                  Tx_Timeout,
  output logic                  Sched_Busy
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                  state, state_nxt;
  logic [ALU_WIDTH-1:0]    alu_dat, alu_dat_nxt;
  logic [DATA_WIDTH-1:0]   rd_dat, rd_dat_nxt;
  logic                    pend_alu, pend_alu_nxt;
  logic                    pend_rd, pend_rd_nxt;
  logic                    last_alu, last_alu_nxt;   // 1: last grant went to ALU
  logic [ALU_WIDTH-1:0]    sr, sr_nxt;
  logic [1:0]              bytes_left, bytes_left_nxt;
  logic [7:0]              tmo_cnt, tmo_cnt_nxt;
  logic [DATA_WIDTH-1:0]   tx_dat_nxt;
  logic                    tx_vld_nxt;
  logic                    ovr_alu_nxt, ovr_rd_nxt, tmo_nxt, sched_nxt;
  logic                    grant_ok, grant_alu, grant_rd;

  // On a tie, the requester that did not win last time is granted.
  assign grant_ok  = (state == IDLE) && !Busy;
  assign grant_alu = grant_ok && pend_alu && (!pend_rd || !last_alu);
  assign grant_rd  = grant_ok && pend_rd  && (!pend_alu || last_alu);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      alu_dat     <= '0;
      rd_dat      <= '0;
      pend_alu    <= 1'b0;
      pend_rd     <= 1'b0;
      last_alu    <= 1'b1;
      sr          <= '0;
      bytes_left  <= '0;
      tmo_cnt     <= '0;
      TX_P_Data   <= '0;
      TX_D_VLD    <= 1'b0;
      Overrun_ALU <= 1'b0;
      Overrun_Rd  <= 1'b0;
      Tx_Timeout  <= 1'b0;
      Sched_Busy  <= 1'b0;
    end else begin
      state       <= state_nxt;
      alu_dat     <= alu_dat_nxt;
      rd_dat      <= rd_dat_nxt;
      pend_alu    <= pend_alu_nxt;
      pend_rd     <= pend_rd_nxt;
      last_alu    <= last_alu_nxt;
      sr          <= sr_nxt;
      bytes_left  <= bytes_left_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      TX_P_Data   <= tx_dat_nxt;
      TX_D_VLD    <= tx_vld_nxt;
      Overrun_ALU <= ovr_alu_nxt;
      Overrun_Rd  <= ovr_rd_nxt;
      Tx_Timeout  <= tmo_nxt;
      Sched_Busy  <= sched_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    alu_dat_nxt    = alu_dat;
    rd_dat_nxt     = rd_dat;
    pend_alu_nxt   = pend_alu;
    pend_rd_nxt    = pend_rd;
    last_alu_nxt   = last_alu;
    sr_nxt         = sr;
    bytes_left_nxt = bytes_left;
    tmo_cnt_nxt    = tmo_cnt;
    tx_dat_nxt     = TX_P_Data;
    tx_vld_nxt     = TX_D_VLD;
    ovr_alu_nxt    = 1'b0;
    ovr_rd_nxt     = 1'b0;
    tmo_nxt        = 1'b0;

    // Slots free on their grant edge, so a result arriving on that edge is
    // taken rather than counted as an overrun.
    if (grant_alu) pend_alu_nxt = 1'b0;
    if (grant_rd)  pend_rd_nxt  = 1'b0;
    if (ALU_OUT_VLD) begin
      if (!pend_alu || grant_alu) begin
        alu_dat_nxt  = ALU_OUT;
        pend_alu_nxt = 1'b1;
      end else begin
        ovr_alu_nxt = 1'b1;
      end
    end
    if (RdData_VLD) begin
      if (!pend_rd || grant_rd) begin
        rd_dat_nxt  = RdData;
        pend_rd_nxt = 1'b1;
      end else begin
        ovr_rd_nxt = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        tx_vld_nxt = 1'b0;
        if (grant_alu) begin
          sr_nxt         = alu_dat;
          bytes_left_nxt = 2'd2;
          tx_dat_nxt     = alu_dat[DATA_WIDTH-1:0];
          tx_vld_nxt     = 1'b1;
          last_alu_nxt   = 1'b1;
          tmo_cnt_nxt    = '0;
          state_nxt      = REQ;
        end else if (grant_rd) begin
          sr_nxt         = {{(ALU_WIDTH-DATA_WIDTH){1'b0}}, rd_dat};
          bytes_left_nxt = 2'd1;
          tx_dat_nxt     = rd_dat;
          tx_vld_nxt     = 1'b1;
          last_alu_nxt   = 1'b0;
          tmo_cnt_nxt    = '0;
          state_nxt      = REQ;
        end
      end
      REQ: begin
        if (Busy) begin
          tx_vld_nxt     = 1'b0;
          sr_nxt         = sr >> DATA_WIDTH;
          bytes_left_nxt = bytes_left - 2'd1;
          tmo_cnt_nxt    = '0;
          state_nxt      = DRAIN;
        end else if (tmo_cnt == TMO_LAST) begin
          // Counter holds completed no-Busy REQ cycles; this is the last allowed one.
          tx_vld_nxt     = 1'b0;
          bytes_left_nxt = '0;
          tmo_cnt_nxt    = '0;
          tmo_nxt        = 1'b1;
          state_nxt      = IDLE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 8'd1;
        end
      end
      DRAIN: begin
        tx_vld_nxt = 1'b0;
        if (!Busy) begin
          if (bytes_left != 2'd0) begin
            tx_dat_nxt = sr[DATA_WIDTH-1:0];
            tx_vld_nxt = 1'b1;
            state_nxt  = REQ;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        tx_vld_nxt = 1'b0;
        state_nxt  = IDLE;
      end
    endcase

    sched_nxt = pend_alu_nxt | pend_rd_nxt | (state_nxt != IDLE);
  end

endmodule

// File: doc/tx_frame_scheduler.md
# tx_frame_scheduler

Schedules response traffic from the REF_CLK domain onto the UART transmitter. It captures one-shot results from two requesters, the ALU (16-bit) and the register file read port (8-bit). It arbitrates between them round-robin and serialises each result into byte frames for the TX data synchroniser, handshaking on the synchronised UART `Busy`. It sits between ALU/Reg_File and the TX DATA_SYNC/BUSY BIT_SYNC, in the REF_CLK domain.

## Interface
- `ALU_WIDTH`, 16: ALU result width; must be 2×`DATA_WIDTH`.
- `DATA_WIDTH`, 8: UART frame payload width.
- `TIMEOUT_CYCLES`, 255: max cycles to wait for `Busy` rising in REQ (1..255; 8-bit counter).
- `CLK` in 1: REF_CLK domain clock; all logic on rising edge.
- `RST` in 1: reset, asynchronous, active-low.
- `ALU_OUT` in `ALU_WIDTH`: ALU result, valid with `ALU_OUT_VLD`.
- `ALU_OUT_VLD` in 1: single-cycle valid pulse for the ALU result.
- `RdData` in `DATA_WIDTH`: register-file read data.
- `RdData_VLD` in 1: single-cycle valid pulse for `RdData`.
- `Busy` in 1: UART TX busy, already synchronised to `CLK`.
- `TX_P_Data` out `DATA_WIDTH`: byte to transmit; registered.
- `TX_D_VLD` out 1: transmit request level; registered.
- `Overrun_ALU` out 1: one-cycle pulse when an ALU result is dropped.
- `Overrun_Rd` out 1: one-cycle pulse when a read result is dropped.
- `Tx_Timeout` out 1: one-cycle pulse when a frame is aborted.
- `Sched_Busy` out 1: high while any slot is pending or FSM not IDLE.

## Operation
- Reset: all outputs 0; slots empty; FSM IDLE; `last_grant` = ALU, so RD wins the first tie; counters 0.
- Capture slots: one per requester, each holding data plus a pending flag.
  - VLD with slot empty → capture; pending=1.
  - VLD with slot pending → new data dropped, old kept, `Overrun_x` pulses next cycle.
  - A slot frees on the edge it is granted. A VLD arriving in that same cycle is captured with no overrun.
- Arbitration in IDLE only, when `Busy`=0:
  - One slot pending → grant it.
  - Both pending → grant the one ≠ `last_grant`.
  - `last_grant` updates at grant.
- On grant:
  - Slot data is copied to the 16-bit shift register `sr`.
  - `bytes_left` is set: ALU=2, RD=1.
  - ALU bytes are sent low byte first (`ALU_OUT[7:0]`), then `[15:8]`.
- FSM states:
  - IDLE: `TX_D_VLD`=0. On grant → REQ, loading `TX_P_Data`=`sr[7:0]` and `TX_D_VLD`=1.
  - REQ: `TX_D_VLD`=1 and `TX_P_Data` held stable; timeout counter increments each cycle.
    - `Busy`=1 → DRAIN with `TX_D_VLD`=0; `sr` shifts right 8; `bytes_left`-1; counter clears.
    - Counter reaching `TIMEOUT_CYCLES` before `Busy`=1 → abort the rest of the frame, pulse `Tx_Timeout`, go to IDLE with `TX_D_VLD`=0.
  - DRAIN: `TX_D_VLD`=0; wait for `Busy`=0.
    - `bytes_left`>0 → REQ with the next byte.
    - Otherwise → IDLE.
- `TX_P_Data` holds its last value outside REQ; it is not cleared.
- `Sched_Busy` = `pend_alu | pend_rd | (state≠IDLE)`, registered.

## Timing
- VLD sampled at edge k → pending at k.
- With FSM IDLE and `Busy`=0, grant happens at edge k+1, and `TX_D_VLD` is high after k+1. Latency is 1 cycle from capture.
- `TX_D_VLD` falls on the edge after `Busy` is first sampled high. It never stays asserted once `Busy` is seen.
- The next REQ begins on the edge after `Busy` is sampled low, so there is a minimum 1 idle cycle between bytes.
- Back-to-back frames: after the final DRAIN→IDLE, a pending slot is granted on the following edge.
- Timeout: abort occurs on the `TIMEOUT_CYCLES`-th REQ cycle with no `Busy`. The slot that was granted is not restored.
- Async reset mid-frame: immediate return to reset state. The partial frame is lost and no pulses are emitted.

## Test plan
- Single read: `RdData`=0xA5 pulse, with `Busy` model rising 3 cycles after `TX_D_VLD` and falling 10 cycles later → one REQ with `TX_P_Data`=0xA5, `TX_D_VLD` dropped the cycle after `Busy`, back to IDLE, `Sched_Busy`=0.
- ALU frame: `ALU_OUT`=0x1234 → bytes 0x34 then 0x12, each gated by a full Busy high/low cycle.
- Tie and round-robin: both VLD in the same cycle after reset → RD 0x5A sent before ALU 0xBEEF. A second simultaneous pair → ALU sent first.
- Overrun: two `RdData_VLD` pulses, 0x11 then 0x22, while a long ALU frame is in flight → `Overrun_Rd` one pulse, then 0x11 sent and 0x22 never sent. A VLD in the grant cycle → captured, no overrun.
- Timeout: `Busy` tied 0, `TIMEOUT_CYCLES`=8 → `Tx_Timeout` pulse after 8 REQ cycles, `TX_D_VLD`=0, ALU high byte not sent.
- Reset mid-frame: assert `RST`=0 during DRAIN of ALU byte 1 → all outputs 0 immediately; after release, no residual transmission.
